// File: rtl/gpio_op_sequencer.sv
// Operand sequencer: buffers (a1, a2) pairs in a FIFO and runs each through a fixed
// write/poll/read exchange on a strobed peripheral bus, returning the read-back result.
module gpio_op_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int POLL_LIMIT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [23:0] op_a1,
    input  logic [23:0] op_a2,
    output logic [15:0] saddress,
    output logic        swr,
    output logic        srd,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_w,
    output logic [23:0] res_l,
    output logic [1:0]  res_b,
    output logic        res_err,
    output logic        busy
);
    localparam int T      = SETUP_CYCLES + STROBE_CYCLES + 1;
    localparam int CYC_W  = $clog2(T + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PCNT_W = $clog2(POLL_LIMIT + 1);

    localparam logic [CYC_W-1:0]  CYC_STB    = CYC_W'(SETUP_CYCLES);
    localparam logic [CYC_W-1:0]  CYC_SAMPLE = CYC_W'(SETUP_CYCLES + STROBE_CYCLES - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(T - 1);
    localparam logic [PCNT_W-1:0] POLL_FINAL = PCNT_W'(POLL_LIMIT - 1);

    typedef enum logic [2:0] {IDLE, WR_A1, WR_A2, WR_GO, POLL, RD_W, RD_L, OUT} state_t;

    state_t            state, state_next;
    logic [CYC_W-1:0]  cyc, cyc_next;
    logic [PCNT_W-1:0] poll_cnt, poll_next;
    logic [1:0]        status;
    logic [23:0]       cur_a1, cur_a2;
    logic              push, pop, fifo_empty, strobe_win, sample, last;

    logic [47:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    assign op_ready   = (count != CNT_W'(FIFO_DEPTH));
    assign push       = op_valid && op_ready;
    assign fifo_empty = (count == '0);
    assign busy       = (state != IDLE) || !fifo_empty;
    assign res_valid  = (state == OUT);
    assign strobe_win = (cyc >= CYC_STB) && (cyc <= CYC_SAMPLE);
    assign sample     = (cyc == CYC_SAMPLE);
    assign last       = (cyc == CYC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {op_a1, op_a2};
        if (pop)  {cur_a1, cur_a2} <= mem[rd_ptr];
        if (state == POLL && sample) status <= m_rdata[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cyc      <= '0;
            poll_cnt <= '0;
        end else begin
            state    <= state_next;
            cyc      <= cyc_next;
            poll_cnt <= poll_next;
        end
    end

    // Every bus state spends exactly T cycles; cyc wraps to 0 on the state change.
    always_comb begin
        state_next = state;
        cyc_next   = cyc;
        poll_next  = poll_cnt;
        pop        = 1'b0;
        if (state != IDLE && state != OUT)
            cyc_next = last ? '0 : cyc + CYC_W'(1);
        unique case (state)
            IDLE: if (!fifo_empty) begin
                state_next = WR_A1;
                pop        = 1'b1;
            end
            WR_A1: if (last) state_next = WR_A2;
            WR_A2: if (last) state_next = WR_GO;
            WR_GO: if (last) begin
                state_next = POLL;
                poll_next  = '0;
            end
            POLL: if (last) begin
                if (status == 2'b11)          state_next = RD_W;
                else if (poll_cnt == POLL_FINAL) state_next = OUT;
                else                          poll_next  = poll_cnt + PCNT_W'(1);
            end
            RD_W: if (last) state_next = RD_L;
            RD_L: if (last) state_next = OUT;
            OUT: if (res_ready) begin
                if (!fifo_empty) begin
                    state_next = WR_A1;
                    pop        = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        saddress = 16'h0;
        m_wdata  = 32'h0;
        swr      = 1'b0;
        srd      = 1'b0;
        unique case (state)
            WR_A1: begin saddress = 16'h037F; m_wdata = {8'h0, cur_a1}; swr = strobe_win; end
            WR_A2: begin saddress = 16'h0388; m_wdata = {8'h0, cur_a2}; swr = strobe_win; end
            WR_GO: begin saddress = 16'h03A0; swr = strobe_win; end
            POLL:  begin saddress = 16'h03A0; srd = strobe_win; end
            RD_W:  begin saddress = 16'h0390; srd = strobe_win; end
            RD_L:  begin saddress = 16'h0398; srd = strobe_win; end
            default: ;
        endcase
    end

    // Result payload only changes while reading, so it is frozen for the whole OUT state.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_w   <= '0;
            res_l   <= '0;
            res_b   <= '0;
            res_err <= 1'b0;
        end else begin
            if (state == POLL && last) begin
                if (status == 2'b11) begin
                    res_b   <= 2'b11;
                    res_err <= 1'b0;
                end else if (poll_cnt == POLL_FINAL) begin
                    res_b   <= status;
                    res_err <= 1'b1;
                    res_w   <= '0;
                    res_l   <= '0;
                end
            end
            if (state == RD_W && sample) res_w <= m_rdata;
            if (state == RD_L && sample) res_l <= m_rdata[23:0];
        end
    end
endmodule

// File: tb/tb_gpio_op_sequencer.sv
// Scoreboard bench for gpio_op_sequencer with a behavioural peripheral on the strobed bus.
module tb_gpio_op_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [23:0] op_a1 = '0, op_a2 = '0;
    logic [15:0] saddress;
    logic        swr, srd;
    logic [31:0] m_wdata, m_rdata;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_w;
    logic [23:0] res_l;
    logic [1:0]  res_b;
    logic        res_err, busy;

    always #5 clk = ~clk;

    gpio_op_sequencer #(.FIFO_DEPTH(4), .SETUP_CYCLES(1), .STROBE_CYCLES(2), .POLL_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_a1(op_a1), .op_a2(op_a2), .saddress(saddress), .swr(swr), .srd(srd),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .res_valid(res_valid), .res_ready(res_ready),
        .res_w(res_w), .res_l(res_l), .res_b(res_b), .res_err(res_err), .busy(busy)
    );

    typedef struct packed {logic err; logic [31:0] w; logic [23:0] l; logic [1:0] b;} res_t;
    typedef struct packed {logic wr; logic [15:0] addr; logic [31:0] data;} txn_t;

    res_t expq[$];
    int   pollq[$];
    txn_t txq[$];
    int   n_checks = 0, n_fail = 0, cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Peripheral: W = (a1+a2)*a1, L = a1/a2; status stays 00 for cur_fail reads, then 11.
    logic [23:0] pa1 = '0, pa2 = '0;
    int          cur_fail = 0, polls_done = 0, st_reads = 0, w_reads = 0, l_reads = 0;
    logic        swr_q = 1'b0, srd_q = 1'b0;
    logic [15:0] addr_q = '0;
    logic [31:0] w_val;
    logic [23:0] l_val;

    assign w_val = (32'(pa1) + 32'(pa2)) * 32'(pa1);
    assign l_val = (pa2 == 24'h0) ? 24'h0 : pa1 / pa2;

    always_comb begin
        m_rdata = 32'h0;
        if (srd) begin
            case (saddress)
                16'h03A0: m_rdata = (polls_done >= cur_fail) ? 32'h1234_5673 : 32'h1234_5674;
                16'h0390: m_rdata = w_val;
                16'h0398: m_rdata = {8'hA5, l_val};
                default:  m_rdata = 32'hBAD0_BAD0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (swr || srd) begin
            n_checks++;
            if (swr && srd) begin
                n_fail++;
                $display("FAIL strobe_overlap: swr=%b srd=%b required never both high", swr, srd);
            end
        end
        if ((swr && swr_q) || (srd && srd_q)) begin
            n_checks++;
            if (saddress !== addr_q) begin
                n_fail++;
                $display("FAIL addr_stable: got %h required %h", saddress, addr_q);
            end
        end
        if (swr && !swr_q) begin
            txq.push_back({1'b1, saddress, m_wdata});
            if (saddress == 16'h037F) begin
                pa1 = m_wdata[23:0];
                polls_done = 0;
                if (pollq.size() > 0) cur_fail = pollq.pop_front();
                else cur_fail = 0;
            end
            if (saddress == 16'h0388) pa2 = m_wdata[23:0];
        end
        if (srd && !srd_q) begin
            txq.push_back({1'b0, saddress, 32'h0});
            if (saddress == 16'h03A0) st_reads++;
            if (saddress == 16'h0390) w_reads++;
            if (saddress == 16'h0398) l_reads++;
        end
        if (!srd && srd_q && saddress == 16'h03A0) polls_done++;
        swr_q  = swr;
        srd_q  = srd;
        addr_q = saddress;
    end

    // Monitor: a result is consumed on the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            n_checks++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got w=%h l=%h b=%b err=%b, none queued", res_w, res_l, res_b, res_err);
            end else begin
                res_t e;
                e = expq.pop_front();
                if ({res_err, res_w, res_l, res_b} !== e) begin
                    n_fail++;
                    $display("FAIL result: got w=%h l=%h b=%b err=%b required w=%h l=%h b=%b err=%b",
                             res_w, res_l, res_b, res_err, e.w, e.l, e.b, e.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic push_op(input logic [23:0] a1, input logic [23:0] a2, input int fails,
                           input res_t exp, output int acc);
        int g = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_a1 = a1;
        op_a2 = a2;
        while (!op_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!op_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: op_ready=%b required 1", op_ready);
            op_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc_cnt + 1;
        expq.push_back(exp);
        pollq.push_back(fails);
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic wait_res(input int limit, output int at);
        int g = 0;
        at = -1;
        while (g < limit) begin
            @(negedge clk);
            if (res_valid) begin
                at = cyc_cnt;
                break;
            end
            g++;
        end
        if (at < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL res_timeout: res_valid=%b required 1 within %0d cycles", res_valid, limit);
        end
    endtask

    task automatic drain(input int limit);
        int g = 0;
        while (expq.size() != 0 && g < limit) begin
            @(negedge clk);
            g++;
        end
        chk("drain_pending", 64'(expq.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   acc, at, seen;
        int   accs[5];
        txn_t exp_tx[6];

        repeat (3) @(negedge clk);
        chk("rst_op_ready", 64'(op_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_payload", 64'({res_err, res_w, res_l, res_b}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_bus", 64'({saddress, swr, srd, m_wdata}), 64'd0);
        reset = 1'b0;

        // Single op, status ready on first poll.
        txq.delete();
        push_op(24'h5, 24'h3, 0, '{1'b0, 32'h28, 24'h1, 2'b11}, acc);
        wait_res(100, at);
        chk("lat_single", 64'(at - acc), 64'd25);
        drain(50);
        exp_tx[0] = '{1'b1, 16'h037F, 32'h5};
        exp_tx[1] = '{1'b1, 16'h0388, 32'h3};
        exp_tx[2] = '{1'b1, 16'h03A0, 32'h0};
        exp_tx[3] = '{1'b0, 16'h03A0, 32'h0};
        exp_tx[4] = '{1'b0, 16'h0390, 32'h0};
        exp_tx[5] = '{1'b0, 16'h0398, 32'h0};
        chk("bus_txn_count", 64'(txq.size()), 64'd6);
        for (int i = 0; i < 6 && i < txq.size(); i++)
            chk($sformatf("bus_txn%0d", i), 64'(txq[i]), 64'(exp_tx[i]));
        chk("idle_bus", 64'({saddress, swr, srd, m_wdata}), 64'd0);

        // Three not-ready polls, full-scale operands.
        st_reads = 0;
        push_op(24'hFFFFFF, 24'h1, 3, '{1'b0, 32'hFF00_0000, 24'hFFFFFF, 2'b11}, acc);
        wait_res(200, at);
        chk("lat_poll3", 64'(at - acc), 64'd37);
        drain(50);
        chk("status_reads_poll3", 64'(st_reads), 64'd4);

        // Status never ready: error after POLL_LIMIT reads.
        st_reads = 0; w_reads = 0; l_reads = 0;
        push_op(24'h40, 24'h2, 1000, '{1'b1, 32'h0, 24'h0, 2'b00}, acc);
        wait_res(200, at);
        chk("lat_poll_err", 64'(at - acc), 64'd45);
        drain(50);
        chk("status_reads_err", 64'(st_reads), 64'd8);
        chk("data_reads_err", 64'(w_reads + l_reads), 64'd0);

        // Back-pressure: five ops fill the FIFO behind the one in flight.
        res_ready = 1'b0;
        push_op(24'h10, 24'h2, 0, '{1'b0, 32'h120, 24'h8, 2'b11}, accs[0]);
        push_op(24'h7, 24'h7, 1, '{1'b0, 32'h62, 24'h1, 2'b11}, accs[1]);
        push_op(24'h3, 24'h9, 0, '{1'b0, 32'h24, 24'h0, 2'b11}, accs[2]);
        push_op(24'h100, 24'h10, 2, '{1'b0, 32'h11000, 24'h10, 2'b11}, accs[3]);
        push_op(24'h21, 24'h4, 0, '{1'b0, 32'h4C5, 24'h8, 2'b11}, accs[4]);
        @(negedge clk);
        chk("full_op_ready", 64'(op_ready), 64'd0);
        chk("full_busy", 64'(busy), 64'd1);
        wait_res(100, at);
        chk("lat_first_of_five", 64'(at - accs[0]), 64'd25);
        repeat (3) @(negedge clk);
        chk("hold_valid", 64'(res_valid), 64'd1);
        chk("hold_w", 64'(res_w), 64'h120);
        chk("hold_l", 64'(res_l), 64'h8);
        res_ready = 1'b1;
        drain(1000);
        chk("drained_op_ready", 64'(op_ready), 64'd1);

        // Reset while swr is high during WR_A2.
        push_op(24'h11, 24'h22, 0, '{1'b0, 32'h0, 24'h0, 2'b11}, acc);
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            @(negedge clk);
            if (swr && saddress == 16'h0388) seen = 1;
        end
        chk("reach_wr_a2_strobe", 64'(seen), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        expq.delete();
        pollq.delete();
        chk("rst_mid_swr", 64'(swr), 64'd0);
        chk("rst_mid_op_ready", 64'(op_ready), 64'd1);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_bus", 64'({saddress, srd, m_wdata}), 64'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("no_result_after_reset", 64'(seen), 64'd0);

        // Recovery after reset.
        push_op(24'h7, 24'h7, 0, '{1'b0, 32'h62, 24'h1, 2'b11}, acc);
        wait_res(100, at);
        chk("lat_after_reset", 64'(at - acc), 64'd25);
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
